// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: monitors a two-digit multiplexed seven-segment display,
// decodes the scanned glyphs back into BCD, and publishes the score once it
// has held for STABLE_FRAMES consecutive identical frames.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   an[3:0]    anode lines, active-low (1110 = ones, 1101 = tens, else idle)
//   seg[6:0]   cathode lines, active-low {g,f,e,d,c,b,a}
//   ones[3:0]  published ones digit
//   tens[3:0]  published tens digit
//   value[6:0] published tens*10+ones
//   update     one-cycle pulse when the published value changes
//   locked     high while published data is current
//   err_count  invalid glyph samples, saturating at 255
module seg_scan_decoder #(
  parameter int unsigned SETTLE        = 4,
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned TIMEOUT       = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] value,
  output logic       update,
  output logic       locked,
  output logic [7:0] err_count
);

  localparam int unsigned AN_W     = 4;
  localparam int unsigned DIG_W    = 4;
  localparam int unsigned VAL_W    = 7;
  localparam int unsigned ERR_W    = 8;
  localparam int unsigned SETTLE_W = 8;
  localparam int unsigned STAB_W   = 4;
  localparam int unsigned TO_W     = 24;

  localparam logic [AN_W-1:0]     AN_ONES    = 4'b1110;
  localparam logic [AN_W-1:0]     AN_TENS    = 4'b1101;
  localparam logic [AN_W-1:0]     AN_IDLE    = 4'b1111;
  localparam logic [SETTLE_W-1:0] SETTLE_LD  = SETTLE_W'(SETTLE);
  localparam logic [STAB_W-1:0]   STAB_MAX   = STAB_W'(STABLE_FRAMES);
  localparam logic [TO_W-1:0]     TO_MAX     = TO_W'(TIMEOUT);
  localparam logic [ERR_W-1:0]    ERR_MAX    = '1;

  typedef enum logic {
    WAIT_ONES = 1'b0,
    WAIT_TENS = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [AN_W-1:0]       an_q;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [DIG_W-1:0]      ones_cand_q, ones_cand_d;
  logic [2*DIG_W-1:0]    prev_q, prev_d;
  logic [STAB_W-1:0]     stab_q, stab_d, stab_inc_c;
  logic [TO_W-1:0]       to_q, to_d;
  logic [DIG_W-1:0]      ones_d, tens_d;
  logic [VAL_W-1:0]      value_d;
  logic                  update_d, locked_d;
  logic [ERR_W-1:0]      err_d;

  logic                  glyph_ok_c;
  logic [DIG_W-1:0]      glyph_dig_c;
  logic                  sample_c;
  logic                  bad_sample_c, ones_sample_c, tens_sample_c, frame_done_c;
  logic [2*DIG_W-1:0]    frame_pair_c;

  // Glyph table: active-low {g,f,e,d,c,b,a} to BCD digit
  always_comb begin
    glyph_ok_c  = 1'b1;
    glyph_dig_c = '0;
    case (seg)
      7'b1000000: glyph_dig_c = 4'd0;
      7'b1111001: glyph_dig_c = 4'd1;
      7'b0100100: glyph_dig_c = 4'd2;
      7'b0110000: glyph_dig_c = 4'd3;
      7'b0011001: glyph_dig_c = 4'd4;
      7'b0010010: glyph_dig_c = 4'd5;
      7'b0000010: glyph_dig_c = 4'd6;
      7'b1111000: glyph_dig_c = 4'd7;
      7'b0000000: glyph_dig_c = 4'd8;
      7'b0010000: glyph_dig_c = 4'd9;
      default:    glyph_ok_c  = 1'b0;
    endcase
  end

  // Settle counter fires once per dwell, on its 1 -> 0 step with an unchanged
  always_comb begin
    settle_d = settle_q;
    if (an != an_q) begin
      settle_d = SETTLE_LD;
    end else if (settle_q != '0) begin
      settle_d = SETTLE_W'(settle_q - SETTLE_W'(1));
    end
  end

  assign sample_c      = (an == an_q) && (settle_q == SETTLE_W'(1)) &&
                         ((an == AN_ONES) || (an == AN_TENS));
  assign bad_sample_c  = sample_c && !glyph_ok_c;
  assign ones_sample_c = sample_c && glyph_ok_c && (an == AN_ONES);
  assign tens_sample_c = sample_c && glyph_ok_c && (an == AN_TENS);
  assign frame_done_c  = tens_sample_c && (state_q == WAIT_TENS);
  assign frame_pair_c  = {glyph_dig_c, ones_cand_q};
  assign stab_inc_c    = (stab_q >= STAB_MAX) ? STAB_MAX : STAB_W'(stab_q + STAB_W'(1));

  // Frame FSM, stability tracking, publishing and timeout
  always_comb begin
    state_d     = state_q;
    ones_cand_d = ones_cand_q;
    prev_d      = prev_q;
    stab_d      = stab_q;
    to_d        = to_q;
    ones_d      = ones;
    tens_d      = tens;
    value_d     = value;
    update_d    = 1'b0;
    locked_d    = locked;
    err_d       = err_count;

    if (bad_sample_c) begin
      err_d   = (err_count == ERR_MAX) ? err_count : ERR_W'(err_count + ERR_W'(1));
      state_d = WAIT_ONES;
      stab_d  = '0;
    end else if (ones_sample_c) begin
      ones_cand_d = glyph_dig_c;
      state_d     = WAIT_TENS;
    end else if (frame_done_c) begin
      state_d = WAIT_ONES;
      if (frame_pair_c == prev_q) begin
        stab_d = stab_inc_c;
      end else begin
        stab_d = STAB_W'(1);
        prev_d = frame_pair_c;
      end
      if (stab_d == STAB_MAX) begin
        update_d = (frame_pair_c != {tens, ones}) || !locked;
        ones_d   = ones_cand_q;
        tens_d   = glyph_dig_c;
        value_d  = VAL_W'(VAL_W'(glyph_dig_c) * VAL_W'(10) + VAL_W'(ones_cand_q));
        locked_d = 1'b1;
      end
    end

    // A completing frame takes priority over an expiring timeout
    if (frame_done_c) begin
      to_d = '0;
    end else if (to_q != TO_MAX) begin
      to_d = TO_W'(to_q + TO_W'(1));
      if (to_d == TO_MAX) begin
        locked_d = 1'b0;
        stab_d   = '0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_ONES;
      an_q        <= AN_IDLE;
      settle_q    <= '0;
      ones_cand_q <= '0;
      prev_q      <= '0;
      stab_q      <= '0;
      to_q        <= '0;
      ones        <= '0;
      tens        <= '0;
      value       <= '0;
      update      <= 1'b0;
      locked      <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      an_q        <= an;
      settle_q    <= settle_d;
      ones_cand_q <= ones_cand_d;
      prev_q      <= prev_d;
      stab_q      <= stab_d;
      to_q        <= to_d;
      ones        <= ones_d;
      tens        <= tens_d;
      value       <= value_d;
      update      <= update_d;
      locked      <= locked_d;
      err_count   <= err_d;
    end
  end

endmodule
